// File: rtl/pc_gen_unit_if.sv
// Fetch-stage redirect request bundle and PC/status return for pc_gen_unit.
interface pc_gen_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            exc;
  logic [XLEN-1:0] OldPC;
  logic            br_taken;
  logic [XLEN-1:0] br_off;
  logic            j;
  logic            jal;
  logic [25:0]     Adj;
  logic            jr;
  logic            jr_ret;
  logic [XLEN-1:0] jr_target;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] pcjal;
  logic            ras_used;
  logic            ras_underflow;
  logic            align_err;

  // Requester side (decode/execute and fetch consumer)
  modport master (
    output stall, exc, OldPC, br_taken, br_off, j, jal, Adj, jr, jr_ret, jr_target,
    input  PC, pcjal, ras_used, ras_underflow, align_err
  );

  // PC generator side
  modport slave (
    input  stall, exc, OldPC, br_taken, br_off, j, jal, Adj, jr, jr_ret, jr_target,
    output PC, pcjal, ras_used, ras_underflow, align_err
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Program-counter generator: reset/exception vectors, prioritised redirects,
// stall hold and a circular return-address stack predicting jr $ra.
module pc_gen_unit #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int unsigned RAS_DEPTH = 4,
  parameter bit          RAS_EN    = 1'b1
) (
  input  logic         Clk,
  input  logic         PcReSet,
  pc_gen_unit_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pcjal_q;
  logic             ras_used_q;
  logic             ras_underflow_q;
  logic             align_err_q;

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0] ras_cnt;

  logic [XLEN-1:0]  pc_nxt;
  logic [XLEN-1:0]  pcjal_nxt;
  logic [XLEN-1:0]  jr_tgt;
  logic [XLEN-1:0]  link_addr;
  logic [PTR_W-1:0] ptr_m1;
  logic             push;
  logic             pop;
  logic             used_nxt;
  logic             underflow_nxt;
  logic             align_nxt;

  assign ptr_m1    = ras_ptr - PTR_W'(1);
  assign link_addr = bus.OldPC + XLEN'(4);

  // Next-PC selection by priority: exc > stall > jr > branch > jump > sequential
  always_comb begin
    pc_nxt        = pc_q + XLEN'(4);
    pcjal_nxt     = pcjal_q;
    jr_tgt        = bus.jr_target;
    push          = 1'b0;
    pop           = 1'b0;
    used_nxt      = 1'b0;
    underflow_nxt = 1'b0;
    align_nxt     = 1'b0;
    if (bus.exc) begin
      pc_nxt = XLEN'(EXC_VEC);
    end else if (bus.stall) begin
      pc_nxt = pc_q;
    end else if (bus.jr) begin
      if (RAS_EN && bus.jr_ret) begin
        if (ras_cnt != '0) begin
          pop      = 1'b1;
          used_nxt = 1'b1;
          jr_tgt   = ras_mem[ptr_m1];
        end else begin
          underflow_nxt = 1'b1;
        end
      end
      align_nxt = |jr_tgt[1:0];
      pc_nxt    = {jr_tgt[XLEN-1:2], 2'b00};
    end else if (bus.br_taken) begin
      pc_nxt = bus.OldPC + XLEN'(4) + (bus.br_off << 2);
    end else if (bus.j) begin
      pc_nxt = {bus.OldPC[XLEN-1:28], bus.Adj, 2'b00};
      if (bus.jal) begin
        pcjal_nxt = link_addr;
        push      = RAS_EN;
      end
    end
  end

  // PC, link register, RAS bookkeeping and status pulses
  always_ff @(posedge Clk) begin
    if (PcReSet) begin
      pc_q            <= XLEN'(RESET_VEC);
      pcjal_q         <= '0;
      ras_ptr         <= '0;
      ras_cnt         <= '0;
      ras_used_q      <= 1'b0;
      ras_underflow_q <= 1'b0;
      align_err_q     <= 1'b0;
    end else begin
      pc_q            <= pc_nxt;
      pcjal_q         <= pcjal_nxt;
      ras_used_q      <= used_nxt;
      ras_underflow_q <= underflow_nxt;
      align_err_q     <= align_nxt;
      if (pop) begin
        ras_ptr <= ptr_m1;
        ras_cnt <= ras_cnt - CNT_W'(1);
      end else if (push) begin
        // When full the write pointer sits on the oldest entry, so it is overwritten
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (ras_cnt != CNT_W'(RAS_DEPTH)) begin
          ras_cnt <= ras_cnt + CNT_W'(1);
        end
      end
    end
  end

  // RAS storage; contents are meaningless until counted, so no reset needed
  always_ff @(posedge Clk) begin
    if (!PcReSet && push) begin
      ras_mem[ras_ptr] <= link_addr;
    end
  end

  assign bus.PC            = pc_q;
  assign bus.pcjal         = pcjal_q;
  assign bus.ras_used      = ras_used_q;
  assign bus.ras_underflow = ras_underflow_q;
  assign bus.align_err     = align_err_q;

endmodule
